// File: rtl/jump_target_pc_unit.sv
// jump_target_pc_unit
//   Owns the fetch program counter. It applies J-type, JR and taken-branch
//   redirects from decode/execute. A redirect that arrives during a stall is
//   held in a one-entry buffer and applied when the stall drops. Every applied
//   redirect produces a one-cycle IF flush pulse.
// Ports
//   clk, rst_n          : clock (rising edge), async active-low reset
//   stall               : hold pc, no sequential advance
//   j_valid/j_target/j_pc4     : J-type request, target = {pc4[31:28], tgt, 00}
//   jr_valid/jr_addr           : jump-register request, low 2 bits forced to 0
//   br_valid/br_offset/br_pc4  : taken branch, target = pc4 + sext(off)<<2
//   pc, pc_plus4        : registered fetch address and pc + PC_STEP
//   fetch_valid         : pc is a valid fetch this cycle
//   flush_if            : registered pulse, kill the instruction in IF/ID
//   misalign_err        : registered pulse, accepted JR had addr[1:0] != 0
//   redirect_pending    : a redirect is buffered (HELD)
module jump_target_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        j_valid,
  input  logic [25:0] j_target,
  input  logic [31:0] j_pc4,
  input  logic        jr_valid,
  input  logic [31:0] jr_addr,
  input  logic        br_valid,
  input  logic [15:0] br_offset,
  input  logic [31:0] br_pc4,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_valid,
  output logic        flush_if,
  output logic        misalign_err,
  output logic        redirect_pending
);

  localparam logic [0:0] S_RUN  = 1'b0;
  localparam logic [0:0] S_HELD = 1'b1;
  localparam logic [31:0] STEP  = 32'(PC_STEP);

  logic [0:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_q, pend_d;
  logic        flush_q, flush_d;
  logic        mis_q, mis_d;

  logic [31:0] jt, rt, bt, tgt;
  logic        req;

  // Only the segment bits of the jump's pc4 take part in the target.
  logic unused_pc4_low;
  assign unused_pc4_low = ^j_pc4[27:0];

  assign jt  = {j_pc4[31:28], j_target, 2'b00};
  assign rt  = {jr_addr[31:2], 2'b00};
  assign bt  = br_pc4 + {{14{br_offset[15]}}, br_offset, 2'b00};
  assign req = jr_valid | j_valid | br_valid;

  // Priority JR > J > branch; losers in the same cycle are dropped.
  always_comb begin
    tgt = bt;
    if (jr_valid)     tgt = rt;
    else if (j_valid) tgt = jt;
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pend_d  = pend_q;
    flush_d = 1'b0;
    mis_d   = 1'b0;
    if (state_q == S_RUN) begin
      if (req) begin
        mis_d = jr_valid & (jr_addr[1:0] != 2'b00);
        if (!stall) begin
          pc_d    = tgt;
          flush_d = 1'b1;
        end else begin
          pend_d  = tgt;
          state_d = S_HELD;
        end
      end else if (!stall) begin
        pc_d = pc_q + STEP;
      end
    end else begin
      // New requests while held come from the wrong path and are ignored.
      if (!stall) begin
        pc_d    = pend_q;
        flush_d = 1'b1;
        state_d = S_RUN;
        pend_d  = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RUN;
      pc_q    <= RESET_PC;
      pend_q  <= '0;
      flush_q <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      flush_q <= flush_d;
      mis_q   <= mis_d;
    end
  end

  assign pc               = pc_q;
  assign pc_plus4         = pc_q + STEP;
  assign fetch_valid      = rst_n & ~stall & (state_q == S_RUN);
  assign flush_if         = flush_q;
  assign misalign_err     = mis_q;
  assign redirect_pending = (state_q == S_HELD);

endmodule

// File: tb/tb_jump_target_pc_unit.sv
module tb_jump_target_pc_unit;

  logic        clk = 1'b0;
  logic        rst_n, stall;
  logic        j_valid, jr_valid, br_valid;
  logic [25:0] j_target;
  logic [31:0] j_pc4, jr_addr, br_pc4;
  logic [15:0] br_offset;
  logic [31:0] pc, pc_plus4;
  logic        fetch_valid, flush_if, misalign_err, redirect_pending;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [31:0] m_pc, m_pend;
  bit          m_held, m_flush, m_mis;

  always #5 clk = ~clk;

  jump_target_pc_unit #(.RESET_PC(32'h0), .PC_STEP(4)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .j_valid(j_valid), .j_target(j_target), .j_pc4(j_pc4),
    .jr_valid(jr_valid), .jr_addr(jr_addr),
    .br_valid(br_valid), .br_offset(br_offset), .br_pc4(br_pc4),
    .pc(pc), .pc_plus4(pc_plus4), .fetch_valid(fetch_valid),
    .flush_if(flush_if), .misalign_err(misalign_err),
    .redirect_pending(redirect_pending)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_pend = 32'h0; m_held = 0; m_flush = 0; m_mis = 0;
  endtask

  // Spec-level target: what address the winning request asks for.
  function automatic logic [31:0] want_target();
    int signed off;
    if (jr_valid) return jr_addr & ~32'd3;
    if (j_valid)  return (j_pc4 & 32'hF000_0000) | (32'(j_target) << 2);
    off = $signed(br_offset);
    return br_pc4 + 32'(off * 4);
  endfunction

  task automatic model_step();
    bit req;
    req = jr_valid || j_valid || br_valid;
    m_flush = 0;
    m_mis   = 0;
    if (m_held) begin
      if (!stall) begin
        m_pc = m_pend; m_pend = 0; m_held = 0; m_flush = 1;
      end
    end else if (req) begin
      m_mis = jr_valid && (jr_addr % 4 != 0);
      if (!stall) begin m_pc = want_target(); m_flush = 1; end
      else        begin m_pend = want_target(); m_held = 1; end
    end else if (!stall) begin
      m_pc = m_pc + 4;
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".pc"},   pc, m_pc);
    chk({tag, ".pc4"},  pc_plus4, m_pc + 32'd4);
    chk({tag, ".fv"},   32'(fetch_valid), 32'(rst_n && !stall && !m_held));
    chk({tag, ".fl"},   32'(flush_if), 32'(m_flush));
    chk({tag, ".mis"},  32'(misalign_err), 32'(m_mis));
    chk({tag, ".pend"}, 32'(redirect_pending), 32'(m_held));
  endtask

  // Inputs are already driven (at a negedge). Check, clock, advance model.
  task automatic step(input string tag);
    #1;
    check_model(tag);
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic idle();
    j_valid = 0; jr_valid = 0; br_valid = 0;
  endtask

  initial begin
    rst_n = 0; stall = 0; idle();
    j_target = '0; j_pc4 = '0; jr_addr = '0; br_offset = '0; br_pc4 = '0;
    model_reset();
    @(negedge clk); @(negedge clk);
    #1;
    chk("rst.pc",   pc, 32'h0);
    chk("rst.fv",   32'(fetch_valid), 32'h0);
    chk("rst.fl",   32'(flush_if), 32'h0);
    chk("rst.pend", 32'(redirect_pending), 32'h0);
    chk("rst.mis",  32'(misalign_err), 32'h0);
    @(negedge clk);
    rst_n = 1;

    // sequential fetch 0,4,8,12
    for (int i = 0; i < 4; i++) step("seq");
    chk("seq.pc16", pc, 32'd16);

    // J-type redirect
    j_valid = 1; j_pc4 = 32'h4000_0010; j_target = 26'h0000100;
    step("j");
    idle();
    chk("j.pc", pc, 32'h4000_0400);
    chk("j.fl", 32'(flush_if), 32'h1);
    step("j1");
    chk("j1.pc", pc, 32'h4000_0404);
    chk("j1.fl", 32'(flush_if), 32'h0);

    // backward branch
    br_valid = 1; br_pc4 = 32'h0000_0100; br_offset = 16'hFFFC;
    step("br");
    chk("br.pc", pc, 32'h0000_00F0);
    // JR beats J and branch in the same cycle
    jr_valid = 1; jr_addr = 32'h0000_2000; j_valid = 1;
    step("prio");
    idle();
    chk("prio.pc", pc, 32'h0000_2000);

    // stall buffering
    stall = 1; br_valid = 1; br_pc4 = 32'h0000_0100; br_offset = 16'h0040;
    step("st1");
    idle();
    chk("st1.pend", 32'(redirect_pending), 32'h1);
    chk("st1.pc", pc, 32'h0000_2000);
    j_valid = 1; j_pc4 = 32'h8000_0000; j_target = 26'h3;
    step("st2");
    idle();
    step("st3");
    stall = 0;
    step("rel");
    chk("rel.pc", pc, 32'h0000_0200);
    chk("rel.fl", 32'(flush_if), 32'h1);
    step("rel1");
    chk("rel1.pc", pc, 32'h0000_0204);
    chk("rel1.fl", 32'(flush_if), 32'h0);

    // misaligned JR
    jr_valid = 1; jr_addr = 32'h0000_1003;
    step("mis");
    idle();
    chk("mis.pc", pc, 32'h0000_1000);
    chk("mis.err", 32'(misalign_err), 32'h1);
    step("mis1");
    chk("mis1.err", 32'(misalign_err), 32'h0);

    // wrap at top of address space
    jr_valid = 1; jr_addr = 32'hFFFF_FFF8;
    step("wr0");
    idle();
    step("wr1");
    step("wr2");
    chk("wrap.pc", pc, 32'h0);

    // reset in the middle of HELD discards the buffered target
    stall = 1; j_valid = 1; j_pc4 = 32'h0; j_target = 26'h100;
    step("h");
    idle();
    chk("h.pend", 32'(redirect_pending), 32'h1);
    #2 rst_n = 0;
    #1;
    model_reset();
    chk("hr.pc", pc, 32'h0);
    chk("hr.pend", 32'(redirect_pending), 32'h0);
    @(negedge clk);
    rst_n = 1; stall = 0;
    step("hr0");
    chk("hr0.pc", pc, 32'h4);
    chk("hr0.fl", 32'(flush_if), 32'h0);

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      stall     = ($urandom_range(0, 2) == 0);
      jr_valid  = ($urandom_range(0, 5) == 0);
      j_valid   = ($urandom_range(0, 4) == 0);
      br_valid  = ($urandom_range(0, 3) == 0);
      jr_addr   = $urandom;
      j_target  = 26'($urandom);
      j_pc4     = $urandom;
      br_offset = 16'($urandom);
      br_pc4    = $urandom;
      step("rnd");
    end
    idle(); stall = 0;
    step("end");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/jump_target_pc_unit.md
Name: jump_target_pc_unit

Overview:
- Consumer side of the jump-target path. Owns the fetch program counter and applies redirects that arrive from decode/execute.
- Redirect types:
  - J-type: 26-bit target is concatenated with PC+4[31:28] and 2'b00.
  - JR: 32-bit register address.
  - Branch: 16-bit offset, sign-extended and shifted left by 2.
- Buffers one redirect across pipeline stalls and issues a one-cycle IF flush after each applied redirect.
- Sits between the decode/execute redirect logic and the instruction memory address port.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- PC_STEP, 4, sequential increment in bytes.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- stall  input  1  hold PC; no sequential advance.
- j_valid  input  1  J-type redirect request.
- j_target  input  26  instruction target field.
- j_pc4  input  32  PC+4 of the jump instruction.
- jr_valid  input  1  jump-register redirect request.
- jr_addr  input  32  register-sourced target.
- br_valid  input  1  taken-branch redirect request.
- br_offset  input  16  branch immediate.
- br_pc4  input  32  PC+4 of the branch instruction.
- pc  output  32  current fetch address (registered).
- pc_plus4  output  32  pc + PC_STEP (combinational).
- fetch_valid  output  1  pc is a valid fetch this cycle.
- flush_if  output  1  kill the instruction currently in IF/ID (registered pulse).
- misalign_err  output  1  one-cycle pulse: JR target had addr[1:0] != 0.
- redirect_pending  output  1  a redirect is buffered (state HELD).

Behaviour:
- Reset (asynchronous, rst_n=0):
  - pc=RESET_PC, state=RUN.
  - flush_if=0, misalign_err=0, redirect_pending=0, pending register cleared.
  - fetch_valid=0 while rst_n=0; it rises in the first cycle after release.
- Target formation (combinational, all 32-bit):
  - JT = {j_pc4[31:28], j_target, 2'b00}.
  - RT = {jr_addr[31:2], 2'b00}.
  - BT = br_pc4 + {{14{br_offset[15]}}, br_offset, 2'b00}, arithmetic wraps modulo 2^32.
- Request priority when several are valid in the same cycle: jr_valid > j_valid > br_valid. Lower-priority requests that cycle are dropped.
- States:
  - RUN:
    - Request present, stall=0: at the next edge pc<=target, flush_if<=1. Stay in RUN.
    - Request present, stall=1: pend<=target, state<=HELD, redirect_pending=1. pc unchanged.
    - No request, stall=0: pc<=pc+PC_STEP.
    - No request, stall=1: pc holds.
  - HELD:
    - Any new request is ignored; it comes from a younger, wrong-path instruction.
    - stall=1: remain in HELD.
    - stall=0: pc<=pend, flush_if<=1, state<=RUN, pend cleared.
- fetch_valid = rst_n & ~stall & (state==RUN).
- flush_if is high for exactly one cycle after each applied redirect. Back-to-back redirects produce back-to-back pulses.
- misalign_err:
  - Registered, one-cycle pulse in the cycle after a JR request is accepted (into pc or into pend) with jr_addr[1:0] != 0.
  - The redirect still proceeds using RT.
- A request in the same cycle as release from HELD is ignored; the pending target wins.
- Asserting rst_n mid-HELD discards pend.
- pc wraps from 32'hFFFF_FFFC to 32'h0000_0000 on sequential increment.
- Latency: redirect to new pc is 1 cycle when not stalled, or 1 cycle after stall deasserts when buffered.

Test Plan:
- Reset and sequential fetch: release rst_n with RESET_PC=0 and stall=0 → pc steps 0, 4, 8, 12; fetch_valid=1; flush_if=0.
- J-type redirect: j_valid=1, j_pc4=32'h4000_0010, j_target=26'h0000100 → next pc=32'h4000_0400, flush_if=1 for one cycle, then pc=32'h4000_0404.
- Backward branch: br_valid=1, br_pc4=32'h0000_0100, br_offset=16'hFFFC → pc=32'h0000_00F0.
  - Also assert jr_valid with jr_addr=32'h0000_2000 in the same cycle → pc=32'h0000_2000 (JR priority).
- Stall buffering: stall=1 for 3 cycles, br_valid=1 in the first stalled cycle (target 32'h0000_0200), j_valid=1 in the second →
  - redirect_pending=1 and pc unchanged during the stall;
  - after stall drops, pc=32'h0000_0200, flush_if pulses once;
  - the J request is ignored.
- Misaligned JR: jr_valid=1, jr_addr=32'h0000_1003 → pc=32'h0000_1000, misalign_err pulses one cycle.
- Reset mid-HELD: enter HELD, then pull rst_n low asynchronously → pc=RESET_PC immediately; after release, no flush_if and no pending redirect applied.
